// File: rtl/face_detect_pkg.sv
// Shared types and default geometry for the face-scan pipeline: scan FSM states,
// the candidate record, and default frame/window constants.
package face_detect_pkg;

  localparam int DEFAULT_FRAME_WIDTH     = 10;
  localparam int DEFAULT_FRAME_HEIGHT    = 10;
  localparam int DEFAULT_INTEGRAL_LENGTH = 8;
  localparam int DEFAULT_COORD_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SCAN       = 2'd1,
    NEXT_SCALE = 2'd2,
    DONE       = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic [DEFAULT_COORD_WIDTH-1:0] x;
    logic [DEFAULT_COORD_WIDTH-1:0] y;
    logic [3:0]                     scale;
  } cand_rec_t;

endpackage

// File: rtl/candidate_fifo.sv
// Candidate queue: circular buffer with count-based full/empty flags and a
// ready-driven pop. DEPTH must be a power of two, at least 2.
module candidate_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk_os,
  input  logic             reset_fpga,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop;
  logic             write;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign pop   = !empty && ready;
  // A pop frees the head slot this cycle, so a full queue can still accept.
  assign write = push && (!full || pop);

  always_ff @(posedge clk_os) begin
    if (write) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (write) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({write, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/face_scan_controller.sv
// Multi-scale raster scan controller with a candidate queue for first-stage hits.
// Optional SCAN_DROP_COUNT_EN adds a saturating 16-bit o_drop_count output.
module face_scan_controller
  import face_detect_pkg::*;
#(
  parameter int FRAME_WIDTH     = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT    = DEFAULT_FRAME_HEIGHT,
  parameter int COORD_WIDTH     = DEFAULT_COORD_WIDTH,
  parameter int INTEGRAL_LENGTH = DEFAULT_INTEGRAL_LENGTH,
  parameter int NUM_SCALES      = 3,
  parameter int SCALE_STEP      = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clk_os,
  input  logic                   reset_fpga,
  input  logic                   i_start,
  input  logic                   i_pixel_valid,
  input  logic                   i_is_candidate,
  input  logic [COORD_WIDTH-1:0] i_cand_xcoord,
  input  logic [COORD_WIDTH-1:0] i_cand_ycoord,
  output logic [COORD_WIDTH-1:0] o_xcoord,
  output logic [COORD_WIDTH-1:0] o_ycoord,
  output logic [COORD_WIDTH-1:0] o_frame_src_width,
  output logic [COORD_WIDTH-1:0] o_frame_src_height,
  output logic [COORD_WIDTH-1:0] o_frame_dst_width,
  output logic [COORD_WIDTH-1:0] o_frame_dst_height,
  output logic [3:0]             o_scale_idx,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_cand_valid,
  input  logic                   i_cand_ready,
  output logic [COORD_WIDTH-1:0] o_cand_x,
  output logic [COORD_WIDTH-1:0] o_cand_y,
  output logic [3:0]             o_cand_scale,
`ifdef SCAN_DROP_COUNT_EN
  output logic [15:0]            o_drop_count,
`endif
  output logic                   o_dropped
);

  localparam logic [1:0] S_IDLE       = IDLE;
  localparam logic [1:0] S_SCAN       = SCAN;
  localparam logic [1:0] S_NEXT_SCALE = NEXT_SCALE;
  localparam logic [1:0] S_DONE       = DONE;

  localparam int REC_W = 2*COORD_WIDTH + 4;
  // A further pass needs both shrunken dimensions to still hold the window.
  localparam logic [COORD_WIDTH:0] MIN_DIM = (COORD_WIDTH+1)'(INTEGRAL_LENGTH + SCALE_STEP);

  logic [1:0]             state_reg;
  logic [COORD_WIDTH-1:0] x_reg;
  logic [COORD_WIDTH-1:0] y_reg;
  logic [3:0]             scale_reg;
  logic [COORD_WIDTH-1:0] dst_w_reg;
  logic [COORD_WIDTH-1:0] dst_h_reg;
  logic                   dropped_reg;

  logic             last_col;
  logic             last_row;
  logic             more_scales;
  logic             cand_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow;
  logic [REC_W-1:0] head_data;

  assign last_col    = (x_reg == COORD_WIDTH'(FRAME_WIDTH - 1));
  assign last_row    = (y_reg == COORD_WIDTH'(FRAME_HEIGHT - 1));
  assign more_scales = (scale_reg < 4'(NUM_SCALES - 1)) &&
                       ({1'b0, dst_w_reg} >= MIN_DIM) &&
                       ({1'b0, dst_h_reg} >= MIN_DIM);

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      scale_reg <= '0;
      dst_w_reg <= COORD_WIDTH'(FRAME_WIDTH);
      dst_h_reg <= COORD_WIDTH'(FRAME_HEIGHT);
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_start) begin
            state_reg <= S_SCAN;
            x_reg     <= '0;
            y_reg     <= '0;
            scale_reg <= '0;
            dst_w_reg <= COORD_WIDTH'(FRAME_WIDTH);
            dst_h_reg <= COORD_WIDTH'(FRAME_HEIGHT);
          end
        end
        S_SCAN: begin
          if (i_pixel_valid) begin
            if (!last_col) begin
              x_reg <= x_reg + COORD_WIDTH'(1);
            end else begin
              x_reg <= '0;
              if (!last_row) begin
                y_reg <= y_reg + COORD_WIDTH'(1);
              end else begin
                y_reg     <= '0;
                state_reg <= more_scales ? S_NEXT_SCALE : S_DONE;
              end
            end
          end
        end
        S_NEXT_SCALE: begin
          scale_reg <= scale_reg + 4'd1;
          dst_w_reg <= dst_w_reg - COORD_WIDTH'(SCALE_STEP);
          dst_h_reg <= dst_h_reg - COORD_WIDTH'(SCALE_STEP);
          state_reg <= S_SCAN;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign cand_push = (state_reg == S_SCAN) && i_is_candidate;
  // Full implies non-empty, so a ready consumer always makes room this cycle.
  assign overflow  = cand_push && fifo_full && !i_cand_ready;

  candidate_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(REC_W)
  ) u_fifo (
    .clk_os    (clk_os),
    .reset_fpga(reset_fpga),
    .push      (cand_push),
    .push_data ({i_cand_xcoord, i_cand_ycoord, scale_reg}),
    .ready     (i_cand_ready),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) dropped_reg <= 1'b0;
    else            dropped_reg <= overflow;
  end

`ifdef SCAN_DROP_COUNT_EN
  logic [15:0] drop_count_reg;

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga)
      drop_count_reg <= '0;
    else if (state_reg == S_IDLE && i_start)
      drop_count_reg <= '0;
    else if (overflow && drop_count_reg != 16'hFFFF)
      drop_count_reg <= drop_count_reg + 16'd1;
  end

  assign o_drop_count = drop_count_reg;
`else
`endif

  assign o_xcoord           = x_reg;
  assign o_ycoord           = y_reg;
  assign o_scale_idx        = scale_reg;
  assign o_frame_dst_width  = dst_w_reg;
  assign o_frame_dst_height = dst_h_reg;
  assign o_frame_src_width  = COORD_WIDTH'(FRAME_WIDTH);
  assign o_frame_src_height = COORD_WIDTH'(FRAME_HEIGHT);
  assign o_busy             = (state_reg != S_IDLE);
  assign o_frame_done       = (state_reg == S_DONE);
  assign o_cand_valid       = !fifo_empty;
  assign o_dropped          = dropped_reg;
  assign {o_cand_x, o_cand_y, o_cand_scale} = head_data;

endmodule

// File: tb/tb_face_scan_controller.sv
// Bench for face_scan_controller: two instances (window 8 and 9) against a pixel-index
// model plus candidate queue, directed scenarios, then randomized traffic.
module tb_face_scan_controller;
  import face_detect_pkg::*;

  localparam int W = 10, H = 10, CW = 16, NS = 3, STEP = 1, DEPTH = 4;
  localparam int IL_A = 8, IL_B = 9;

  logic clk_os = 1'b0;
  logic reset_fpga = 1'b1;
  logic i_start = 0, i_pixel_valid = 0, i_is_candidate = 0, i_cand_ready = 0;
  logic [CW-1:0] i_cand_xcoord = '0, i_cand_ycoord = '0;

  logic [CW-1:0] a_x, a_y, a_sw, a_sh, a_dw, a_dh, a_cx, a_cy;
  logic [3:0]    a_sc, a_csc;
  logic          a_busy, a_done, a_cv, a_drop;
  logic [CW-1:0] b_x, b_y, b_sw, b_sh, b_dw, b_dh, b_cx, b_cy;
  logic [3:0]    b_sc, b_csc;
  logic          b_busy, b_done, b_cv, b_drop;
`ifdef SCAN_DROP_COUNT_EN
  logic [15:0]   a_dcnt, b_dcnt;
`endif

  int total = 0, bad = 0;

  always #5 clk_os = ~clk_os;

  face_scan_controller #(.INTEGRAL_LENGTH(IL_A)) dut_a (
    .clk_os(clk_os), .reset_fpga(reset_fpga), .i_start(i_start),
    .i_pixel_valid(i_pixel_valid), .i_is_candidate(i_is_candidate),
    .i_cand_xcoord(i_cand_xcoord), .i_cand_ycoord(i_cand_ycoord),
    .o_xcoord(a_x), .o_ycoord(a_y), .o_frame_src_width(a_sw), .o_frame_src_height(a_sh),
    .o_frame_dst_width(a_dw), .o_frame_dst_height(a_dh), .o_scale_idx(a_sc),
    .o_busy(a_busy), .o_frame_done(a_done), .o_cand_valid(a_cv), .i_cand_ready(i_cand_ready),
    .o_cand_x(a_cx), .o_cand_y(a_cy), .o_cand_scale(a_csc),
`ifdef SCAN_DROP_COUNT_EN
    .o_drop_count(a_dcnt),
`endif
    .o_dropped(a_drop));

  face_scan_controller #(.INTEGRAL_LENGTH(IL_B)) dut_b (
    .clk_os(clk_os), .reset_fpga(reset_fpga), .i_start(i_start),
    .i_pixel_valid(i_pixel_valid), .i_is_candidate(i_is_candidate),
    .i_cand_xcoord(i_cand_xcoord), .i_cand_ycoord(i_cand_ycoord),
    .o_xcoord(b_x), .o_ycoord(b_y), .o_frame_src_width(b_sw), .o_frame_src_height(b_sh),
    .o_frame_dst_width(b_dw), .o_frame_dst_height(b_dh), .o_scale_idx(b_sc),
    .o_busy(b_busy), .o_frame_done(b_done), .o_cand_valid(b_cv), .i_cand_ready(i_cand_ready),
    .o_cand_x(b_cx), .o_cand_y(b_cy), .o_cand_scale(b_csc),
`ifdef SCAN_DROP_COUNT_EN
    .o_drop_count(b_dcnt),
`endif
    .o_dropped(b_drop));

  // Model: phase 0 idle, 1 scanning, 2 scale change, 3 frame finished.
  // Position is a linear pixel index within the current pass.
  int m_phase[2] = '{0, 0};
  int m_pix[2]   = '{0, 0};
  int m_pass[2]  = '{0, 0};
  int m_dw[2]    = '{W, W};
  int m_dh[2]    = '{H, H};
  cand_rec_t q[$];
  logic m_dropped = 1'b0;
  int   m_dcnt = 0;

  function automatic int il_of(input int k);
    return (k == 0) ? IL_A : IL_B;
  endfunction

  always @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = 0; m_pix[k] = 0; m_pass[k] = 0; m_dw[k] = W; m_dh[k] = H;
      end
      q.delete();
      m_dropped = 1'b0;
      m_dcnt = 0;
    end else begin
      bit push, pop, was_full;
      cand_rec_t rec;
      push = (m_phase[0] == 1) && i_is_candidate;
      was_full = (q.size() == DEPTH);
      pop = (q.size() > 0) && i_cand_ready;
      rec.x = i_cand_xcoord; rec.y = i_cand_ycoord; rec.scale = 4'(m_pass[0]);
      if (pop) void'(q.pop_front());
      m_dropped = 1'b0;
      if (push) begin
        if (was_full && !pop) begin
          m_dropped = 1'b1;
          if (m_dcnt < 65535) m_dcnt++;
        end else q.push_back(rec);
      end
      if (m_phase[0] == 0 && i_start) m_dcnt = 0;
      for (int k = 0; k < 2; k++) begin
        case (m_phase[k])
          0: if (i_start) begin
               m_phase[k] = 1; m_pix[k] = 0; m_pass[k] = 0; m_dw[k] = W; m_dh[k] = H;
             end
          1: if (i_pixel_valid) begin
               if (m_pix[k] == W*H - 1) begin
                 m_pix[k] = 0;
                 if (m_pass[k] < NS - 1 && m_dw[k] - STEP >= il_of(k) && m_dh[k] - STEP >= il_of(k))
                   m_phase[k] = 2;
                 else
                   m_phase[k] = 3;
               end else m_pix[k]++;
             end
          2: begin m_pass[k]++; m_dw[k] -= STEP; m_dh[k] -= STEP; m_phase[k] = 1; end
          default: m_phase[k] = 0;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_fsm(input string tag, input int k, input logic busy, input logic done,
                         input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [3:0] sc,
                         input logic [CW-1:0] dw, input logic [CW-1:0] dh,
                         input logic [CW-1:0] sw, input logic [CW-1:0] sh);
    check({tag, " busy"}, 32'(busy), 32'(m_phase[k] != 0));
    check({tag, " frame_done"}, 32'(done), 32'(m_phase[k] == 3));
    check({tag, " xcoord"}, 32'(x), 32'(m_pix[k] % W));
    check({tag, " ycoord"}, 32'(y), 32'(m_pix[k] / W));
    check({tag, " scale_idx"}, 32'(sc), 32'(m_pass[k]));
    check({tag, " dst_w"}, 32'(dw), 32'(m_dw[k]));
    check({tag, " dst_h"}, 32'(dh), 32'(m_dh[k]));
    check({tag, " src_w"}, 32'(sw), 32'(W));
    check({tag, " src_h"}, 32'(sh), 32'(H));
  endtask

  always @(negedge clk_os) begin
    cmp_fsm("a", 0, a_busy, a_done, a_x, a_y, a_sc, a_dw, a_dh, a_sw, a_sh);
    cmp_fsm("b", 1, b_busy, b_done, b_x, b_y, b_sc, b_dw, b_dh, b_sw, b_sh);
    check("a cand_valid", 32'(a_cv), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("a cand_x", 32'(a_cx), 32'(q[0].x));
      check("a cand_y", 32'(a_cy), 32'(q[0].y));
      check("a cand_scale", 32'(a_csc), 32'(q[0].scale));
    end
    check("a dropped", 32'(a_drop), 32'(m_dropped));
`ifdef SCAN_DROP_COUNT_EN
    check("a drop_count", 32'(a_dcnt), 32'(m_dcnt));
`endif
  end

  task automatic cyc();
    @(posedge clk_os);
    #2;
  endtask

  task automatic strobe();
    i_pixel_valid = 1; cyc(); i_pixel_valid = 0;
  endtask

  task automatic do_reset();
    reset_fpga = 1; cyc(); reset_fpga = 0; cyc();
  endtask

  task automatic start_frame();
    i_start = 1; cyc(); i_start = 0;
  endtask

  initial begin
    int done_a_cnt, done_a_at, done_b_cnt, done_b_at, drops;
    repeat (3) cyc();
    // Reset state, pinned by literals.
    check("rst busy", 32'(a_busy), 0);
    check("rst cand_valid", 32'(a_cv), 0);
    check("rst dst_w", 32'(a_dw), 10);
    check("rst frame_done", 32'(a_done), 0);
    reset_fpga = 0; cyc();

    // Full frame: three passes for window 8, two for window 9.
    start_frame();
    done_a_cnt = 0; done_a_at = 0; done_b_cnt = 0; done_b_at = 0;
    for (int k = 1; k <= 300; k++) begin
      strobe();
      if (a_done) begin done_a_cnt++; done_a_at = k; end
      if (b_done) begin done_b_cnt++; done_b_at = k; end
      cyc();
      if (k == 150) begin
        check("p150 a scale", 32'(a_sc), 1);
        check("p150 a dst_w", 32'(a_dw), 9);
        check("p150 b scale", 32'(b_sc), 1);
      end
      if (k == 250) begin
        check("p250 a scale", 32'(a_sc), 2);
        check("p250 a dst_h", 32'(a_dh), 8);
        check("p250 b busy", 32'(b_busy), 0);
      end
    end
    check("a done count", 32'(done_a_cnt), 1);
    check("a done strobe", 32'(done_a_at), 300);
    check("b done count", 32'(done_b_cnt), 1);
    check("b done strobe", 32'(done_b_at), 200);
    check("a idle after frame", 32'(a_busy), 0);

    // Start during SCAN and a strobe during the scale change are both ignored.
    start_frame();
    repeat (5) begin strobe(); cyc(); end
    check("x after 5", 32'(a_x), 5);
    start_frame();
    check("x after restart", 32'(a_x), 5);
    check("busy after restart", 32'(a_busy), 1);
    i_pixel_valid = 1;
    repeat (96) cyc();
    i_pixel_valid = 0;
    check("x after next_scale", 32'(a_x), 0);
    check("y after next_scale", 32'(a_y), 0);
    check("scale after next_scale", 32'(a_sc), 1);

    // Overflow: fifth push with no consumer is discarded.
    do_reset();
    start_frame();
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      i_is_candidate = 1; i_cand_xcoord = CW'(i + 1); i_cand_ycoord = CW'(i + 11);
      cyc();
      if (a_drop) drops++;
    end
    i_is_candidate = 0;
    repeat (2) begin cyc(); if (a_drop) drops++; end
    check("ovf drop pulses", 32'(drops), 1);
    check("ovf cand_valid", 32'(a_cv), 1);
    check("ovf head x", 32'(a_cx), 1);
`ifdef SCAN_DROP_COUNT_EN
    check("ovf drop_count", 32'(a_dcnt), 1);
`endif

    // Full queue, push and pop together: both succeed, order kept.
    i_cand_ready = 1; i_is_candidate = 1; i_cand_xcoord = 99; i_cand_ycoord = 98;
    cyc();
    i_is_candidate = 0;
    check("pp dropped", 32'(a_drop), 0);
    check("pp head x", 32'(a_cx), 2);
    cyc(); check("drain head 3", 32'(a_cx), 3);
    cyc(); check("drain head 4", 32'(a_cx), 4);
    cyc(); check("drain head 99", 32'(a_cx), 99);
    check("drain head y", 32'(a_cy), 98);
    cyc(); check("drain empty", 32'(a_cv), 0);
    i_cand_ready = 0;

    // Reset mid-scan with queued candidates.
    do_reset();
    start_frame();
    repeat (37) begin strobe(); cyc(); end
    i_is_candidate = 1; i_cand_xcoord = 7; cyc();
    i_cand_xcoord = 8; cyc();
    i_is_candidate = 0;
    check("pre-reset cand_valid", 32'(a_cv), 1);
    reset_fpga = 1;
    #1;
    check("midrst busy", 32'(a_busy), 0);
    check("midrst cand_valid", 32'(a_cv), 0);
    check("midrst x", 32'(a_x), 0);
    check("midrst y", 32'(a_y), 0);
    check("midrst frame_done", 32'(a_done), 0);
    cyc(); reset_fpga = 0; cyc();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      reset_fpga     = ($urandom_range(0, 799) == 0);
      i_start        = ($urandom_range(0, 39) == 0);
      i_pixel_valid  = ($urandom_range(0, 3) != 0);
      i_is_candidate = ($urandom_range(0, 2) == 0);
      i_cand_ready   = $urandom_range(0, 1);
      i_cand_xcoord  = CW'($urandom_range(0, 1023));
      i_cand_ycoord  = CW'($urandom_range(0, 1023));
      cyc();
    end
    reset_fpga = 0; i_start = 0; i_pixel_valid = 0; i_is_candidate = 0; i_cand_ready = 0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/face_scan_controller.md
FACE_SCAN_CONTROLLER -- requirements
Module: face_scan_controller

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 10, source frame width in pixels.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 10, source frame height in pixels.
REQ-003 SHALL have parameter COORD_WIDTH, default 16, coordinate and dimension width.
REQ-004 SHALL have parameter INTEGRAL_LENGTH, default 8, detection window side.
REQ-005 SHALL have parameter NUM_SCALES, default 3, maximum scale passes per frame.
REQ-006 SHALL have parameter SCALE_STEP, default 1, destination-dimension decrement per scale.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4 (power of two), candidate queue depth.
REQ-008 SHALL have ports: clk_os in 1 clock; reset_fpga in 1 reset; i_start in 1 frame start pulse; i_pixel_valid in 1 pixel strobe; i_is_candidate in 1 first-stage pass; i_cand_xcoord in COORD_WIDTH; i_cand_ycoord in COORD_WIDTH.
REQ-009 SHALL have ports: o_xcoord, o_ycoord out COORD_WIDTH; o_frame_src_width, o_frame_src_height, o_frame_dst_width, o_frame_dst_height out COORD_WIDTH; o_scale_idx out 4; o_busy out 1; o_frame_done out 1.
REQ-010 SHALL have ports: o_cand_valid out 1; i_cand_ready in 1; o_cand_x, o_cand_y out COORD_WIDTH; o_cand_scale out 4; o_dropped out 1.
REQ-011 Reset reset_fpga SHALL be asynchronous, active-high; all logic SHALL be clocked on clk_os.

Function
REQ-012 FSM states SHALL be IDLE, SCAN, NEXT_SCALE, DONE.
REQ-013 IDLE->SCAN on i_start; scale_idx:=0, coords:=0, dst dims:=FRAME_WIDTH/FRAME_HEIGHT; i_start outside IDLE SHALL be ignored.
REQ-014 In SCAN each i_pixel_valid SHALL advance o_xcoord; at FRAME_WIDTH-1 it wraps to 0 and o_ycoord increments; coords change on the cycle after the strobe.
REQ-015 Strobe at (FRAME_WIDTH-1, FRAME_HEIGHT-1) SHALL end the pass: coords wrap to (0,0); go NEXT_SCALE if scale_idx<NUM_SCALES-1 and next dst dims >=INTEGRAL_LENGTH, else DONE.
REQ-016 NEXT_SCALE SHALL last one cycle: scale_idx+1, dst dims each minus SCALE_STEP, return to SCAN; strobes in this cycle SHALL be ignored.
REQ-017 DONE SHALL last one cycle, assert o_frame_done for exactly that cycle, then go IDLE.
REQ-018 o_busy SHALL be 1 in every state except IDLE; o_frame_src_* SHALL be constant FRAME_WIDTH/FRAME_HEIGHT.
REQ-019 i_is_candidate in SCAN SHALL push {i_cand_xcoord, i_cand_ycoord, scale_idx} into the FIFO; outside SCAN it SHALL be ignored.
REQ-020 o_cand_valid SHALL equal FIFO non-empty; head SHALL drive o_cand_x/y/scale; pop on o_cand_valid&&i_cand_ready.
REQ-021 Push to full FIFO with no pop SHALL be discarded and pulse o_dropped one cycle; push and pop in the same cycle when full SHALL both succeed.
REQ-022 Push into empty FIFO SHALL make o_cand_valid 1 the next cycle (latency 1); output data SHALL hold stable while valid && !ready.

Reset
REQ-023 Reset SHALL force IDLE, coords 0, scale_idx 0, dst dims FRAME_WIDTH/FRAME_HEIGHT, FIFO empty, o_cand_valid/o_busy/o_frame_done/o_dropped 0.
REQ-024 Reset mid-SCAN SHALL abort the frame and flush queued candidates without emitting o_frame_done.

Configuration
REQ-025 With SCAN_DROP_COUNT_EN defined the block SHALL add output o_drop_count (16 bit), counting discarded pushes, saturating at 0xFFFF, cleared on reset and on i_start accepted in IDLE.
REQ-026 Without SCAN_DROP_COUNT_EN the port and counter SHALL be absent; o_dropped behaviour unchanged.

Structure
REQ-027 Package face_detect_pkg SHALL hold the FSM state enum, the candidate record typedef {x, y, scale}, and default FRAME_*/INTEGRAL_LENGTH constants.
REQ-028 The queue SHALL be sub-module candidate_fifo (parameterised depth/width, valid/ready pop, full/empty flags).

Verification
REQ-029 i_start, 100 strobes, NUM_SCALES=3: dst 10->9->8, o_scale_idx 0,1,2, o_frame_done once after strobe 300.
REQ-030 INTEGRAL_LENGTH=9: only 2 passes (dst 10, 9); o_frame_done after strobe 200.
REQ-031 5 candidates with i_cand_ready=0: o_cand_valid 1, 5th push drops, o_dropped pulses once; drop count 1 if macro on.
REQ-032 FIFO full, push and ready same cycle: no drop, occupancy stays 4, head order preserved.
REQ-033 Reset at strobe 37 with 2 queued candidates: o_busy 0, o_cand_valid 0, coords (0,0), no o_frame_done.
REQ-034 i_start during SCAN and strobe during NEXT_SCALE: both ignored, coordinates unchanged.
